// File: rtl/serial_tx_fsm.sv
// Bit-serial framed transmitter: start bit, DATA_W data bits LSB first, optional even parity
// (compiled in with SERIAL_TX_PARITY_EN), stop bit; each bit held DIV cycles on a registered tx line.
module serial_tx_fsm #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign bit_end  = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (in_valid && in_ready) begin
          state_d = S_START;
          shift_d = in_data;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^in_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so the registered line lines up with state_q.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_tx_fsm.sv
// Directed bench for serial_tx_fsm with DATA_W=8, DIV=2; frame layout follows SERIAL_TX_PARITY_EN.
module tb_serial_tx_fsm;

  localparam int W   = 8;
  localparam int DIV = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + 2 + PAR;
  localparam int FL = NB * DIV;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, tx, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  serial_tx_fsm #(.DATA_W(W), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame as sent on tx, index 0 first; p is the hand-computed even parity of w.
  function automatic logic [10:0] frame_bits(input logic [7:0] w, input logic p);
    if (PAR != 0) return {1'b1, p, w, 1'b0};
    else          return {1'b0, 1'b1, w, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, tx, busy, done} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_hold: {rdy,tx,busy,done}=%b want 0100", {in_ready, tx, busy, done});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, tx, busy, done} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_idle c%0d: {rdy,tx,busy,done}=%b want 1100", c, {in_ready, tx, busy, done});
      end
    end
  endtask

  // Sends 0xA5 (parity 0) and 0x07 (parity 1), checking every cycle of each frame.
  task automatic test_single_frame();
    logic [7:0]  words [2] = '{8'hA5, 8'h07};
    logic        pars  [2] = '{1'b0, 1'b1};
    logic [10:0] fb;
    for (int f = 0; f < 2; f++) begin
      fb = frame_bits(words[f], pars[f]);
      in_valid = 1'b1;
      in_data  = words[f];
      for (int k = 0; k < FL; k++) begin
        @(posedge clk); #1;
        if (k == 0) in_valid = 1'b0;
        n_cmp++;
        if ({tx, busy, done} !== {fb[k/DIV], 2'b10}) begin
          n_err++;
          $display("FAIL frame%0d k%0d: {tx,busy,done}=%b want %b", f, k, {tx, busy, done}, {fb[k/DIV], 2'b10});
        end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, tx, busy, done} !== 4'b1101) begin
        n_err++;
        $display("FAIL frame%0d_done: {rdy,tx,busy,done}=%b want 1101", f, {in_ready, tx, busy, done});
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL frame%0d_done_once: done=%b want 0", f, done);
      end
    end
  endtask

  // in_valid stays high; in_data is changed mid-frame to the next word, which must not leak in.
  task automatic test_back_to_back();
    logic [10:0] fb;
    in_valid = 1'b1;
    in_data  = 8'h01;
    fb = frame_bits(8'h01, 1'b1);
    for (int k = 0; k < FL; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_data = 8'hFF;
      n_cmp++;
      if ({tx, busy} !== {fb[k/DIV], 1'b1}) begin
        n_err++;
        $display("FAIL b2b_f1 k%0d: {tx,busy}=%b want %b", k, {tx, busy}, {fb[k/DIV], 1'b1});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, tx, busy, done} !== 4'b1101) begin
      n_err++;
      $display("FAIL b2b_gap: {rdy,tx,busy,done}=%b want 1101", {in_ready, tx, busy, done});
    end
    fb = frame_bits(8'hFF, 1'b0);
    for (int k = 0; k < FL; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
      n_cmp++;
      if ({tx, busy, done} !== {fb[k/DIV], 2'b10}) begin
        n_err++;
        $display("FAIL b2b_f2 k%0d: {tx,busy,done}=%b want %b", k, {tx, busy, done}, {fb[k/DIV], 2'b10});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({tx, busy, done} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_f2_done: {tx,busy,done}=%b want 101", {tx, busy, done});
    end
    @(posedge clk); #1;
  endtask

  // A one-cycle in_valid pulse with 0x3C mid-frame must be ignored entirely.
  task automatic test_handshake();
    logic [10:0] fb;
    fb = frame_bits(8'h96, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h96;
    for (int k = 0; k < FL; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
      if (k == 5) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL hs_ready_busy: in_ready=%b want 0", in_ready);
        end
      end
      if (k == 6) in_valid = 1'b0;
      n_cmp++;
      if ({tx, busy} !== {fb[k/DIV], 1'b1}) begin
        n_err++;
        $display("FAIL hs_frame k%0d: {tx,busy}=%b want %b", k, {tx, busy}, {fb[k/DIV], 1'b1});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL hs_done: done=%b want 1", done);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({tx, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL hs_no_second c%0d: {tx,busy,done}=%b want 100", c, {tx, busy, done});
      end
    end
  endtask

  // Reset during data bit 3 (frame index 4), then a clean frame of 0x5A.
  task automatic test_reset_mid();
    logic [10:0] fb;
    fb = frame_bits(8'hC3, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    for (int k = 0; k <= 4 * DIV; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
      n_cmp++;
      if (tx !== fb[k/DIV]) begin
        n_err++;
        $display("FAIL rst_mid_pre k%0d: tx=%b want %b", k, tx, fb[k/DIV]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, tx, busy, done} !== 4'b0100) begin
      n_err++;
      $display("FAIL rst_mid_async: {rdy,tx,busy,done}=%b want 0100", {in_ready, tx, busy, done});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < FL; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({tx, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL rst_mid_quiet c%0d: {tx,busy,done}=%b want 100", c, {tx, busy, done});
      end
    end
    fb = frame_bits(8'h5A, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int k = 0; k < FL; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
      n_cmp++;
      if ({tx, busy} !== {fb[k/DIV], 1'b1}) begin
        n_err++;
        $display("FAIL rst_mid_next k%0d: {tx,busy}=%b want %b", k, {tx, busy}, {fb[k/DIV], 1'b1});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({tx, busy, done} !== 3'b101) begin
      n_err++;
      $display("FAIL rst_mid_next_done: {tx,busy,done}=%b want 101", {tx, busy, done});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
